fifo_flagged: RTL and testbench

- Parametrised synchronous FIFO, single clock domain; next generation of the team's basic FIFO.
- Adds occupancy count, programmable almost-full/almost-empty thresholds and defined behaviour for simultaneous read/write at full and empty.
- Sits between producer and consumer datapaths in the same clock domain as a rate-smoothing buffer.

---
 rtl/fifo_flagged.sv | 127 ++++++++++++
 tb/tb_fifo_flagged.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flagged
// Description : Single-clock show-ahead FIFO with occupancy count, registered
//               empty/full/almost flags and defined behaviour for simultaneous
//               read/write at full and at empty.
//               Optional sticky overflow/underflow flags are built only when
//               the macro FIFO_ERR_FLAGS_EN is defined; otherwise both outputs
//               are tied low and err_clr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flagged #(
    parameter int B         = 8,
    parameter int W         = 4,
    parameter int AF_THRESH = 2**W - 2,
    parameter int AE_THRESH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] wr_data,
    input  logic         rd,
    output logic [B-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         err_clr
);

    localparam int         c_DEPTH     = 2**W;
    localparam logic [W:0] c_DEPTH_CNT = (W+1)'(c_DEPTH);
    localparam logic [W:0] c_AF        = (W+1)'(AF_THRESH);
    localparam logic [W:0] c_AE        = (W+1)'(AE_THRESH);
    localparam logic       c_AF_RST    = (AF_THRESH == 0);

    logic [B-1:0] mem_q [c_DEPTH];

    logic [W:0] wr_ptr_q, wr_ptr_d;
    logic [W:0] rd_ptr_q, rd_ptr_d;
    logic [W:0] count_q,  count_d;
    logic       empty_q, full_q, ae_q, af_q;
    logic       w_rd_acc, w_wr_acc;

    // Accept logic and next-state pointers/count; a write into a full FIFO is
    // allowed only when the head word leaves in the same cycle.
    always_comb begin
        w_rd_acc = rd & ~empty_q;
        w_wr_acc = wr & (~full_q | w_rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_wr_acc && !w_rd_acc)      count_d = count_q + 1'b1;
        else if (w_rd_acc && !w_wr_acc) count_d = count_q - 1'b1;
    end

    // Pointer, count and flag registers; flags come from next-state count so
    // they never lag the count by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= c_AF_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == c_DEPTH_CNT);
            ae_q     <= (count_d <= c_AE);
            af_q     <= (count_d >= c_AF);
        end
    end

    // Storage array (not reset); at full with a same-cycle read the overwrite
    // lands on the edge, after the head word has already been presented.
    always_ff @(posedge clk) begin
        if (reset && w_wr_acc) begin
            mem_q[wr_ptr_q[W-1:0]] <= wr_data;
        end
    end

    assign rd_data      = mem_q[rd_ptr_q[W-1:0]];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    // Sticky error flags; a clear request wins over a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (err_clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr && full_q && !w_wr_acc) ovf_q <= 1'b1;
            if (rd && empty_q)             udf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_flagged.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flagged
// Description : Self-checking bench for fifo_flagged (B=8, W=4) using a queue
//               model of FIFO occupancy and order plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flagged;

    localparam int c_B     = 8;
    localparam int c_W     = 4;
    localparam int c_DEPTH = 16;
    localparam int c_AF    = 14;
    localparam int c_AE    = 2;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wr = 1'b0;
    logic [c_B-1:0] wr_data = '0;
    logic           rd = 1'b0;
    logic           err_clr = 1'b0;
    logic [c_B-1:0] rd_data;
    logic           empty, full, almost_empty, almost_full;
    logic [c_W:0]   count;
    logic           overflow, underflow;

    fifo_flagged #(
        .B(c_B), .W(c_W), .AF_THRESH(c_AF), .AE_THRESH(c_AE)
    ) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .rd(rd),
        .rd_data(rd_data), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: contents as an ordered queue, sticky flags as bits.
    logic [c_B-1:0] m_q[$];
    bit             m_ovf, m_udf;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Applies one clock edge's worth of requests to the model.
    task automatic model_step(input bit w, input bit r, input logic [c_B-1:0] d, input bit ec);
        bit was_empty, was_full, r_acc, w_acc;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == c_DEPTH);
        r_acc     = r && !was_empty;
        w_acc     = w && (!was_full || r_acc);
        if (r_acc) void'(m_q.pop_front());
        if (w_acc) m_q.push_back(d);
        if (ec) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && was_full && !w_acc) m_ovf = 1'b1;
            if (r && was_empty)          m_udf = 1'b1;
        end
    endtask

    // Compares every DUT output against the model.
    task automatic compare_all();
        int n;
        n = m_q.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == c_DEPTH));
        chk("almost_empty", int'(almost_empty), int'(n <= c_AE));
        chk("almost_full", int'(almost_full), int'(n >= c_AF));
        chk("overflow", int'(overflow), int'(c_ERR_EN && m_ovf));
        chk("underflow", int'(underflow), int'(c_ERR_EN && m_udf));
        if (n != 0) chk("rd_data", int'(rd_data), int'(m_q[0]));
    endtask

    // One clock cycle: drive after the falling edge, sample on the next one.
    task automatic cyc(input bit w, input bit r, input logic [c_B-1:0] d, input bit ec);
        wr = w; rd = r; wr_data = d; err_clr = ec;
        @(posedge clk);
        model_step(w, r, d, ec);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        while (m_q.size() != 0) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        logic [c_B-1:0] seq;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("pin_reset_empty", int'(empty), 1);
        chk("pin_reset_count", int'(count), 0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill with 0x00..0x0F, then read back in order.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk("pin_af_from14", int'(almost_full), int'(i + 1 >= 14));
        end
        chk("pin_fill_count", int'(count), 16);
        chk("pin_fill_full", int'(full), 1);
        for (int i = 0; i < 16; i++) begin
            chk("pin_read_seq", int'(rd_data), i);
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk("pin_drained_empty", int'(empty), 1);

        // Full, then simultaneous read and write of 0xA5.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
        chk("pin_full_head", int'(rd_data), 0);
        cyc(1'b1, 1'b1, 8'hA5, 1'b0);
        chk("pin_full_rw_count", int'(count), 16);
        chk("pin_full_rw_full", int'(full), 1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pin_last_a5", int'(rd_data), 'hA5);
        drain();

        // Empty, simultaneous read and write of 0x3C.
        cyc(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("pin_empty_rw_count", int'(count), 1);
        chk("pin_empty_rw_data", int'(rd_data), 'h3C);
        chk("pin_underflow", int'(underflow), int'(c_ERR_EN));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pin_underflow_clr", int'(underflow), 0);
        drain();

        // Overflow on a lone write while full, then clear.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 1'b0, 8'h77, 1'b0);
        chk("pin_ovf_count", int'(count), 16);
        chk("pin_ovf_head", int'(rd_data), 'h40);
        chk("pin_overflow", int'(overflow), int'(c_ERR_EN));
        cyc(1'b1, 1'b0, 8'h78, 1'b1);
        chk("pin_overflow_clr", int'(overflow), 0);
        drain();

        // 40 interleaved write/read pairs exercising pointer wrap.
        seq = 8'h10;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, seq, 1'b0);
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            seq = seq + 8'd1;
        end

        // Randomized traffic with a mid-burst asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            bit w, r, ec;
            w  = ($urandom_range(0, 99) < (i < 300 ? 65 : 40));
            r  = ($urandom_range(0, 99) < (i < 300 ? 40 : 65));
            ec = ($urandom_range(0, 19) == 0);
            cyc(w, r, 8'($urandom), ec);
            if (i == 250) begin
                wr = 1'b1; rd = 1'b0;
                #2 reset = 1'b0;
                #1;
                model_reset();
                chk("pin_async_count", int'(count), 0);
                chk("pin_async_empty", int'(empty), 1);
                chk("pin_async_full", int'(full), 0);
                @(negedge clk);
                compare_all();
                wr = 1'b0;
                reset = 1'b1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
